// File: rtl/inst_feeder_pkg.sv
// Shared types and constants for the instruction feeder.
package inst_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    HC_NONE      = 2'd0,
    HC_PC_OOR    = 2'd1,
    HC_SELF_LOOP = 2'd2,
    HC_TIMEOUT   = 2'd3
  } halt_cause_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] JAL_SELF = 32'h0000_006F;  // jal x0,0

  // Saturating 32-bit increment used by all run statistics.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/inst_feeder_if.sv
// Core-side bus between the feeder (master) and the cpu core (slave).
interface inst_feeder_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic            store;
  logic            load;
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] d;
  logic [XLEN-1:0] inst;
  logic            cpu_n_rst;

  modport master (
    input  pc, store, load, address, d,
    output inst, cpu_n_rst
  );

  modport slave (
    output pc, store, load, address, d,
    input  inst, cpu_n_rst
  );
endinterface

// File: rtl/inst_feeder_mem.sv
// Program buffer: synchronous write port, asynchronous read port.
module inst_feeder_mem #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];

  // Append port; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_feeder.sv
// Instruction-stream driver for the cpu core: loadable program buffer
// indexed by pc, core reset ownership, store/load statistics and halt
// detection. Optional store trace enabled by INST_FEEDER_TRACE_EN.
module inst_feeder
  import inst_feeder_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 64,
  parameter logic [XLEN-1:0] BASE       = '0,
  parameter int unsigned     MAX_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     prog_we_i,
  input  logic [XLEN-1:0]          prog_data_i,
  input  logic                     start_i,
  inst_feeder_if.master            core,
  output logic                     running_o,
  output logic                     halted_o,
  output logic                     overflow_o,
  output logic [1:0]               halt_cause_o,
  output logic [$clog2(DEPTH):0]   prog_len_o,
  output logic [31:0]              cycle_cnt_o,
  output logic [31:0]              store_cnt_o,
  output logic [31:0]              load_cnt_o,
  output logic [XLEN-1:0]          last_st_addr_o,
  output logic [XLEN-1:0]          last_st_data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e          state_q, state_d;
  halt_cause_e     cause_q, cause_d;
  logic [AW:0]     len_q, len_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     cyc_q, cyc_d, st_q, st_d, ld_q, ld_d;

  logic [XLEN-1:0] off;
  logic            in_range;
  logic [XLEN-1:0] rdata;
  logic            mem_we;
  logic [AW-1:0]   waddr;

  assign off      = core.pc - BASE;
  assign in_range = (core.pc >= BASE) && (off[1:0] == 2'b00) &&
                    ((off >> 2) < XLEN'(len_q));

  assign mem_we = prog_we_i && !clear_i &&
                  ((state_q == ST_IDLE) ||
                   ((state_q == ST_LOAD) && (len_q != (AW+1)'(DEPTH))));
  assign waddr  = (state_q == ST_IDLE) ? '0 : len_q[AW-1:0];

  inst_feeder_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (waddr),
    .wdata_i (prog_data_i),
    .raddr_i (off[AW+1:2]),
    .rdata_o (rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Status and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q <= HC_NONE;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= '0;
      st_q    <= '0;
      ld_q    <= '0;
    end else begin
      cause_q <= cause_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
      st_q    <= st_d;
      ld_q    <= ld_d;
    end
  end

  // Next state: clear first, then load/start handling and RUN halt checks.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    cyc_d   = cyc_q;
    st_d    = st_q;
    ld_d    = ld_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      cause_d = HC_NONE;
      len_d   = '0;
      ovf_d   = 1'b0;
      cyc_d   = '0;
      st_d    = '0;
      ld_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (prog_we_i) begin
            len_d   = (AW+1)'(1);
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          // A write in the same cycle as start still lands before RUN.
          if (prog_we_i) begin
            if (len_q == (AW+1)'(DEPTH)) ovf_d = 1'b1;
            else                         len_d = len_q + (AW+1)'(1);
          end
          if (start_i) begin
            state_d = ST_RUN;
            cyc_d   = '0;
            st_d    = '0;
            ld_d    = '0;
          end
        end
        ST_RUN: begin
          cyc_d = sat_inc(cyc_q);
          if (core.store) st_d = sat_inc(st_q);
          if (core.load)  ld_d = sat_inc(ld_q);
          if (!in_range) begin
            cause_d = HC_PC_OOR;
            state_d = ST_HALT;
          end else if (rdata == XLEN'(JAL_SELF)) begin
            cause_d = HC_SELF_LOOP;
            state_d = ST_HALT;
          end else if (cyc_q == 32'(MAX_CYCLES - 1)) begin
            cause_d = HC_TIMEOUT;
            state_d = ST_HALT;
          end
        end
        ST_HALT: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef INST_FEEDER_TRACE_EN
  logic [XLEN-1:0] tr_addr_q, tr_data_q;

  // Capture the most recent store seen during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tr_addr_q <= '0;
      tr_data_q <= '0;
    end else if (clear_i) begin
      tr_addr_q <= '0;
      tr_data_q <= '0;
    end else if ((state_q == ST_RUN) && core.store) begin
      tr_addr_q <= core.address;
      tr_data_q <= core.d;
    end
  end

  assign last_st_addr_o = tr_addr_q;
  assign last_st_data_o = tr_data_q;
`else
  assign last_st_addr_o = '0;
  assign last_st_data_o = '0;
`endif

  assign core.inst      = ((state_q == ST_RUN) && in_range) ? rdata : XLEN'(NOP_INST);
  assign core.cpu_n_rst = (state_q == ST_RUN) || (state_q == ST_HALT);
  assign running_o      = (state_q == ST_RUN);
  assign halted_o       = (state_q == ST_HALT);
  assign overflow_o     = ovf_q;
  assign halt_cause_o   = cause_q;
  assign prog_len_o     = len_q;
  assign cycle_cnt_o    = cyc_q;
  assign store_cnt_o    = st_q;
  assign load_cnt_o     = ld_q;

endmodule
